// File: rtl/gate_op_pkg.sv
// rtl/gate_op_pkg.sv - op codes, FSM states and result helper for the gate accumulator
package gate_op_pkg;

    localparam logic [1:0] OP_XOR  = 2'b00;
    localparam logic [1:0] OP_NAND = 2'b01;
    localparam logic [1:0] OP_NOR  = 2'b10;
    localparam logic [1:0] OP_XNOR = 2'b11;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_t;

    // Turns the three running reductions into the selected gate output.
    // A fully masked packet leaves the accumulators at their identities,
    // giving XOR=0, NAND=0, NOR=1, XNOR=1 without any special casing.
    function automatic logic op_result(input logic [1:0] code,
                                       input logic and_acc,
                                       input logic or_acc,
                                       input logic xor_acc);
        logic r;
        case (code)
            OP_XOR:  r = xor_acc;
            OP_NAND: r = ~and_acc;
            OP_NOR:  r = ~or_acc;
            default: r = ~xor_acc;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mask_reduce_v.sv
// rtl/mask_reduce_v.sv - per-beat masked AND/OR/XOR reduction with identity fill
module mask_reduce_v #(
    parameter int N_IN = 4
) (
    input  logic [N_IN-1:0] data,
    input  logic [N_IN-1:0] mask,
    output logic            beat_and,
    output logic            beat_or,
    output logic            beat_xor
);

    // Masked lanes are forced to the identity of each reduction (1 for AND, 0 for OR/XOR).
    always_comb begin
        beat_and = &(data | ~mask);
        beat_or  = |(data & mask);
        beat_xor = ^(data & mask);
    end

endmodule

// File: rtl/multi_input_gate_acc_v.sv
// rtl/multi_input_gate_acc_v.sv - streaming N-input code-selected gate reduction over packets
module multi_input_gate_acc_v
    import gate_op_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [N_IN-1:0]  i_data,
    input  logic [N_IN-1:0]  i_mask,
    input  logic [1:0]       i_code,
    input  logic             i_last,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_f,
    output logic [CNT_W-1:0] o_beats
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state, state_n;
    logic [1:0]       code_q, code_n;
    logic             and_acc, and_n;
    logic             or_acc, or_n;
    logic             xor_acc, xor_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             valid_n;
    logic             f_n;
    logic [CNT_W-1:0] beats_n;

    logic beat_and, beat_or, beat_xor;
    logic accept;

    mask_reduce_v #(
        .N_IN (N_IN)
    ) u_reduce (
        .data     (i_data),
        .mask     (i_mask),
        .beat_and (beat_and),
        .beat_or  (beat_or),
        .beat_xor (beat_xor)
    );

    // Input side stalls only while a result is held and not being taken this cycle.
    assign o_ready = ~o_valid | i_ready;
    assign accept  = i_valid & o_ready;

    // Next-state, accumulator fold and result capture for the accepted beat.
    always_comb begin
        state_n = state;
        code_n  = code_q;
        and_n   = and_acc;
        or_n    = or_acc;
        xor_n   = xor_acc;
        cnt_n   = cnt;
        valid_n = o_valid;
        f_n     = o_f;
        beats_n = o_beats;

        if (o_valid && i_ready) begin
            valid_n = 1'b0;
        end

        if (accept) begin
            if (state == ST_IDLE) begin
                // First beat: sample the op and seed straight from the beat.
                code_n = i_code;
                and_n  = beat_and;
                or_n   = beat_or;
                xor_n  = beat_xor;
                cnt_n  = CNT_ONE;
            end else begin
                and_n  = and_acc & beat_and;
                or_n   = or_acc  | beat_or;
                xor_n  = xor_acc ^ beat_xor;
                cnt_n  = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
            end

            if (i_last) begin
                // A new result overrides the consumed one in the same cycle.
                valid_n = 1'b1;
                f_n     = op_result(code_n, and_n, or_n, xor_n);
                beats_n = cnt_n;
                state_n = ST_IDLE;
            end else begin
                state_n = ST_ACCUM;
            end
        end
    end

    // State, accumulators and output register; reset discards any partial packet.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= ST_IDLE;
            code_q  <= OP_XOR;
            and_acc <= 1'b1;
            or_acc  <= 1'b0;
            xor_acc <= 1'b0;
            cnt     <= '0;
            o_valid <= 1'b0;
            o_f     <= 1'b0;
            o_beats <= '0;
        end else begin
            state   <= state_n;
            code_q  <= code_n;
            and_acc <= and_n;
            or_acc  <= or_n;
            xor_acc <= xor_n;
            cnt     <= cnt_n;
            o_valid <= valid_n;
            o_f     <= f_n;
            o_beats <= beats_n;
        end
    end

endmodule

// File: tb/tb_multi_input_gate_acc_v.sv
// tb/tb_multi_input_gate_acc_v.sv - directed self-checking bench for multi_input_gate_acc_v
module tb_multi_input_gate_acc_v;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_valid;
    logic [3:0] i_data;
    logic [3:0] i_mask;
    logic [1:0] i_code;
    logic       i_last;
    logic       i_ready;

    logic       o_ready_a, o_valid_a, o_f_a;
    logic [7:0] o_beats_a;
    logic       o_ready_b, o_valid_b, o_f_b;
    logic [1:0] o_beats_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 i_clk = ~i_clk;

    multi_input_gate_acc_v #(.N_IN(4), .CNT_W(8)) dut_a (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (i_valid),
        .o_ready (o_ready_a),
        .i_data  (i_data),
        .i_mask  (i_mask),
        .i_code  (i_code),
        .i_last  (i_last),
        .o_valid (o_valid_a),
        .i_ready (i_ready),
        .o_f     (o_f_a),
        .o_beats (o_beats_a)
    );

    multi_input_gate_acc_v #(.N_IN(4), .CNT_W(2)) dut_b (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (i_valid),
        .o_ready (o_ready_b),
        .i_data  (i_data),
        .i_mask  (i_mask),
        .i_code  (i_code),
        .i_last  (i_last),
        .o_valid (o_valid_b),
        .i_ready (i_ready),
        .o_f     (o_f_b),
        .o_beats (o_beats_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one beat from a negedge and hold it until dut_a accepts it.
    task automatic send_beat(input logic [3:0] d, input logic [3:0] m,
                             input logic [1:0] c, input logic l);
        int waited;
        waited = 0;
        @(negedge i_clk);
        i_valid = 1'b1;
        i_data  = d;
        i_mask  = m;
        i_code  = c;
        i_last  = l;
        while (!o_ready_a && waited < 20) begin
            @(negedge i_clk);
            waited++;
        end
        if (!o_ready_a) check("accept_timeout", 32'(o_ready_a), 32'd1);
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
    endtask

    // Check the result on the cycle after the last beat was accepted.
    task automatic expect_result(input string tag, input logic f, input logic [7:0] beats);
        @(negedge i_clk);
        check({tag, "_valid"}, 32'(o_valid_a), 32'd1);
        check({tag, "_f"}, 32'(o_f_a), 32'(f));
        check({tag, "_beats"}, 32'(o_beats_a), 32'(beats));
    endtask

    logic [3:0] zero_exp;

    initial begin
        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_data  = '0;
        i_mask  = '0;
        i_code  = '0;
        i_last  = 1'b0;
        i_ready = 1'b1;
        repeat (2) @(negedge i_clk);
        check("rst_valid", 32'(o_valid_a), 32'd0);
        check("rst_f", 32'(o_f_a), 32'd0);
        check("rst_beats", 32'(o_beats_a), 32'd0);
        i_rst = 1'b0;
        @(negedge i_clk);
        check("rst_ready", 32'(o_ready_a), 32'd1);

        send_beat(4'b0111, 4'b1111, 2'b00, 1'b1);
        expect_result("xor1", 1'b1, 8'd1);

        send_beat(4'b1111, 4'b1111, 2'b01, 1'b0);
        send_beat(4'b1111, 4'b1111, 2'b01, 1'b1);
        expect_result("nand_ones", 1'b0, 8'd2);

        send_beat(4'b1111, 4'b1111, 2'b01, 1'b0);
        send_beat(4'b1110, 4'b1111, 2'b01, 1'b1);
        expect_result("nand_zero", 1'b1, 8'd2);

        send_beat(4'b1111, 4'b1111, 2'b01, 1'b0);
        send_beat(4'b1110, 4'b1111, 2'b10, 1'b1);
        expect_result("nand_code_hold", 1'b1, 8'd2);

        send_beat(4'b1010, 4'b0101, 2'b10, 1'b1);
        expect_result("nor_masked", 1'b1, 8'd1);

        zero_exp = 4'b1100;
        for (int c = 0; c < 4; c++) begin
            send_beat(4'b1011, 4'b0000, 2'(c), 1'b1);
            expect_result($sformatf("allmask_op%0d", c), zero_exp[c], 8'd1);
        end

        // Backpressure: pending result must hold and the presented beat must wait.
        @(negedge i_clk);
        i_ready = 1'b0;
        send_beat(4'b0001, 4'b1111, 2'b00, 1'b1);
        @(negedge i_clk);
        i_valid = 1'b1;
        i_data  = 4'b0011;
        i_mask  = 4'b1111;
        i_code  = 2'b00;
        i_last  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp_ready_%0d", k), 32'(o_ready_a), 32'd0);
            check($sformatf("bp_valid_%0d", k), 32'(o_valid_a), 32'd1);
            check($sformatf("bp_f_%0d", k), 32'(o_f_a), 32'd1);
            check($sformatf("bp_beats_%0d", k), 32'(o_beats_a), 32'd1);
            @(negedge i_clk);
        end
        i_ready = 1'b1;
        @(negedge i_clk);
        i_valid = 1'b0;
        check("bp_swap_valid", 32'(o_valid_a), 32'd1);
        check("bp_swap_f", 32'(o_f_a), 32'd0);
        check("bp_swap_beats", 32'(o_beats_a), 32'd1);
        @(negedge i_clk);
        check("bp_no_dup", 32'(o_valid_a), 32'd0);

        send_beat(4'b0001, 4'b1111, 2'b00, 1'b1);
        expect_result("pre_rst", 1'b1, 8'd1);

        // Asynchronous reset in the middle of a NAND packet.
        send_beat(4'b1111, 4'b1111, 2'b01, 1'b0);
        send_beat(4'b1111, 4'b1111, 2'b01, 1'b0);
        @(negedge i_clk);
        #2;
        i_rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(o_valid_a), 32'd0);
        check("mid_rst_f", 32'(o_f_a), 32'd0);
        check("mid_rst_beats", 32'(o_beats_a), 32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        send_beat(4'b0011, 4'b1111, 2'b11, 1'b1);
        expect_result("post_rst_xnor", 1'b1, 8'd1);

        // Five-beat XOR packet: dut_b counter saturates at 3.
        for (int k = 0; k < 5; k++) begin
            send_beat(4'b0001, 4'b1111, 2'b00, (k == 4) ? 1'b1 : 1'b0);
        end
        expect_result("five_beat", 1'b1, 8'd5);
        check("sat_valid", 32'(o_valid_b), 32'd1);
        check("sat_f", 32'(o_f_b), 32'd1);
        check("sat_beats", 32'(o_beats_b), 32'd3);

        @(negedge i_clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
